// File: rtl/transmission_estimator_pipe.sv
// transmission_estimator_pipe
//   Pipelined transmission estimate T(x) = 1 - omega * min_c(Pc/Ac), Q0.DATA_W,
//   floored at a programmable T0. It sits between the dark-channel /
//   atmospheric-ratio stage and the scene-recovery divider.
//   The pipeline has three stages: multiply, subtract/clamp, output register.
//   A valid/ready stream moves through it with no bubble collapsing.
//   Config is latched per frame, and the block counts clamped pixels per frame.
// Ports:
//   clk, rst_n                      rising-edge clock, async active-low reset
//   cfg_omega/cfg_omega_en/cfg_t0   frame config, sampled on the first beat of a frame
//   in_valid/in_ready/in_data/in_eof          input stream
//   out_valid/out_ready/out_data/out_clamped/out_eof  output stream
//   clamp_count/clamp_count_valid   clamped-pixel count of the last frame + update pulse
module transmission_estimator_pipe #(
  parameter int DATA_W    = 14,
  parameter int OMEGA_W   = 8,
  parameter int T0_RST    = 5734,
  parameter int OMEGA_RST = 240,
  parameter int CNT_W     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OMEGA_W-1:0] cfg_omega,
  input  logic               cfg_omega_en,
  input  logic [DATA_W-1:0]  cfg_t0,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_eof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_clamped,
  output logic               out_eof,
  output logic [CNT_W-1:0]   clamp_count,
  output logic               clamp_count_valid
);

  localparam int STAGES = 3;
  localparam int PW     = DATA_W + OMEGA_W;
  localparam logic [DATA_W-1:0] ONE = '1;

  logic               en, in_fire, out_fire;
  logic [STAGES:1]    vld_pipe;

  // frame config
  logic               sof;
  logic [OMEGA_W-1:0] omega_q;
  logic               omega_en_q;
  logic [DATA_W-1:0]  t0_q;
  logic [OMEGA_W-1:0] omega_eff;
  logic               omega_en_eff;
  logic [DATA_W-1:0]  t0_eff;

  // stage 1
  logic [PW-1:0]      prod;
  logic [DATA_W-1:0]  scaled_c;
  logic [DATA_W-1:0]  s1_scaled, s1_t0;
  logic               s1_eof;

  // stage 2
  logic [DATA_W-1:0]  max_t;
  logic               clamp_c;
  logic [DATA_W-1:0]  tdata_c;
  logic [DATA_W-1:0]  s2_data;
  logic               s2_clamped, s2_eof;

  // clamp counter
  logic [CNT_W-1:0]   cnt, cnt_next;

  // The pipeline advances as a whole whenever the output slot is free or draining.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign in_fire   = in_valid && en;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = vld_pipe[STAGES];

  // The first beat of a frame uses the live config inputs.
  // Later beats of the frame use the values latched on that first beat.
  assign omega_eff    = sof ? cfg_omega    : omega_q;
  assign omega_en_eff = sof ? cfg_omega_en : omega_en_q;
  assign t0_eff       = sof ? cfg_t0       : t0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof        <= 1'b1;
      omega_q    <= OMEGA_W'(OMEGA_RST);
      omega_en_q <= 1'b1;
      t0_q       <= DATA_W'(T0_RST);
    end else if (in_fire) begin
      if (sof) begin
        omega_q    <= cfg_omega;
        omega_en_q <= cfg_omega_en;
        t0_q       <= cfg_t0;
      end
      sof <= in_eof;
    end
  end

  // Stage 1: full-precision product, then truncate away the omega fraction.
  assign prod     = PW'(in_data) * PW'(omega_eff);
  assign scaled_c = omega_en_eff ? prod[PW-1:OMEGA_W] : in_data;

  // Stage 2: scaled == max_t gives exactly T0 unclamped.
  // T0 = 0 makes max_t = ONE, so the stage never clamps.
  assign max_t   = ONE - s1_t0;
  assign clamp_c = s1_scaled > max_t;
  assign tdata_c = clamp_c ? s1_t0 : ONE - s1_scaled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      s1_scaled   <= '0;
      s1_t0       <= '0;
      s1_eof      <= 1'b0;
      s2_data     <= '0;
      s2_clamped  <= 1'b0;
      s2_eof      <= 1'b0;
      out_data    <= '0;
      out_clamped <= 1'b0;
      out_eof     <= 1'b0;
    end else if (en) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], in_fire};
      // T0 travels with its beat so a new frame cannot alter in-flight data
      s1_scaled   <= scaled_c;
      s1_t0       <= t0_eff;
      s1_eof      <= in_eof;
      s2_data     <= tdata_c;
      s2_clamped  <= clamp_c;
      s2_eof      <= s1_eof;
      out_data    <= s2_data;
      out_clamped <= s2_clamped;
      out_eof     <= s2_eof;
    end
  end

  // Saturating count of clamped pixels. The update happens only on real
  // output transfers, so a stalled beat is counted once.
  assign cnt_next = (out_clamped && cnt != '1) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt               <= '0;
      clamp_count       <= '0;
      clamp_count_valid <= 1'b0;
    end else begin
      clamp_count_valid <= 1'b0;
      if (out_fire) begin
        if (out_eof) begin
          clamp_count       <= cnt_next;
          clamp_count_valid <= 1'b1;
          cnt               <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_transmission_estimator_pipe.sv
// Directed bench for transmission_estimator_pipe (default parameters).
module tb_transmission_estimator_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_omega;
  logic        cfg_omega_en;
  logic [13:0] cfg_t0;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_data;
  logic        in_eof;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_data;
  logic        out_clamped;
  logic        out_eof;
  logic [19:0] clamp_count;
  logic        clamp_count_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  transmission_estimator_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_omega(cfg_omega), .cfg_omega_en(cfg_omega_en), .cfg_t0(cfg_t0),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eof(in_eof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_clamped(out_clamped), .out_eof(out_eof),
    .clamp_count(clamp_count), .clamp_count_valid(clamp_count_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference for the omega=240, T0=5734, omega enabled case.
  function automatic int tmodel(input int d, output bit cl);
    int s;
    s = (d * 240) >> 8;
    if (s > 16383 - 5734) begin cl = 1'b1; return 5734; end
    cl = 1'b0;
    return 16383 - s;
  endfunction

  // One beat in, wait for it at the output with out_ready held high.
  // The task returns on the negedge where out_valid is seen; that beat
  // transfers on the following posedge.
  task automatic send_wait(input int d, input bit eof, input int exp_d, input bit exp_cl,
                           input bit chk_lat, input string tag);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 14'(d);
    in_eof    = eof;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_eof   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (chk_lat) chk({tag, "_lat"}, lat, 3);
    chk({tag, "_data"}, 32'(out_data), exp_d);
    chk({tag, "_clamp"}, 32'(out_clamped), 32'(exp_cl));
    chk({tag, "_eof"}, 32'(out_eof), 32'(eof));
  endtask

  initial begin
    int vec [10];
    int sent, got, cyc, e;
    bit ecl;

    rst_n = 1'b0; cfg_omega = 8'd240; cfg_omega_en = 1'b1; cfg_t0 = 14'd5734;
    in_valid = 1'b0; in_data = '0; in_eof = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(clamp_count), 0);
    chk("rst_count_valid", 32'(clamp_count_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // single-beat frames with hand-computed results
    send_wait(8192, 1, 8703, 0, 1, "dflt_8192");
    send_wait(16000, 1, 5734, 1, 1, "dflt_16000");
    cfg_omega_en = 1'b0;
    send_wait(10649, 1, 5734, 0, 0, "byp_10649");
    send_wait(10650, 1, 5734, 1, 0, "byp_10650");
    cfg_t0 = 14'd0;
    send_wait(16383, 1, 0, 0, 0, "t0zero_16383");
    cfg_omega_en = 1'b1; cfg_t0 = 14'd5734;

    // stream with random backpressure
    vec = '{8192, 16000, 0, 16383, 11359, 11360, 12000, 100, 9999, 14000};
    sent = 0; got = 0; cyc = 0;
    while (got < 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      in_data   = (sent < 10) ? 14'(vec[sent]) : 14'd0;
      in_eof    = (sent == 9);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        e = tmodel(vec[got], ecl);
        chk("stream_data", 32'(out_data), e);
        chk("stream_clamp", 32'(out_clamped), 32'(ecl));
        chk("stream_eof", 32'(out_eof), 32'(got == 9));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; in_eof = 1'b0; out_ready = 1'b1;
    chk("stream_count", got, 10);
    repeat (4) begin
      @(negedge clk);
      chk("stream_no_extra", 32'(out_valid), 0);
    end

    // frame of 5 beats, 3 clamping
    send_wait(16000, 0, 5734, 1, 0, "frm_b1");
    send_wait(8192, 0, 8703, 0, 0, "frm_b2");
    send_wait(16000, 0, 5734, 1, 0, "frm_b3");
    send_wait(16000, 0, 5734, 1, 0, "frm_b4");
    send_wait(8192, 1, 8703, 0, 0, "frm_b5");
    chk("frm_cv_before", 32'(clamp_count_valid), 0);
    @(negedge clk);
    chk("frm_cv_pulse", 32'(clamp_count_valid), 1);
    chk("frm_count", 32'(clamp_count), 3);
    @(negedge clk);
    chk("frm_cv_after", 32'(clamp_count_valid), 0);
    send_wait(16000, 0, 5734, 1, 0, "frm2_b1");
    send_wait(8192, 1, 8703, 0, 0, "frm2_b2");
    @(negedge clk);
    chk("frm2_cv", 32'(clamp_count_valid), 1);
    chk("frm2_count", 32'(clamp_count), 1);

    // mid-frame config change takes effect only at the next frame
    send_wait(16000, 0, 5734, 1, 0, "mid_b1");
    cfg_t0 = 14'd4096;
    send_wait(12000, 0, 5734, 1, 0, "mid_b2");
    send_wait(12000, 1, 5734, 1, 0, "mid_b3");
    send_wait(12000, 0, 5133, 0, 0, "nxt_b1");
    send_wait(16000, 1, 4096, 1, 0, "nxt_b2");

    // reset with beats in flight
    cfg_t0 = 14'd5734;
    send_wait(16000, 0, 5734, 1, 0, "pre_rst");
    cfg_t0 = 14'd4096;
    @(negedge clk);
    in_valid = 1'b1; in_data = 14'd8192; in_eof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_count", 32'(clamp_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_mid_no_out", 32'(out_valid), 0);
    end
    send_wait(16000, 1, 4096, 1, 1, "post_rst");
    @(negedge clk);
    chk("post_rst_cv", 32'(clamp_count_valid), 1);
    chk("post_rst_count", 32'(clamp_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
